// File: rtl/muldiv_ex.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign correction applied on the last step.
module muldiv_ex #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      rd_in,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            done,
  output logic            busy,
  output logic            stall
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic [XLEN-1:0]  mcand;
  logic             neg_res;
  logic             neg_rem;

  // Operand decode at acceptance
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_neg = A[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM));
    b_neg = B[XLEN-1] & ((op == OP_MULH) | (op == OP_DIV) | (op == OP_REM));
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
    special     = 1'b0;
    special_res = '0;
    if (op[2] && (B == '0)) begin
      special     = 1'b1;
      special_res = op[1] ? A : '1;
    end else if (((op == OP_DIV) || (op == OP_REM)) &&
                 (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1)) begin
      special     = 1'b1;
      special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One iteration: acc_hi holds partial product / remainder, acc_lo the multiplier / quotient
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_trial;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_trial = div_shift - {1'b0, mcand};
    if (op_q[2]) begin
      if (div_trial[XLEN]) begin
        step_hi = div_shift[XLEN-1:0];
        step_lo = {acc_lo[XLEN-2:0], 1'b0};
      end else begin
        step_hi = div_trial[XLEN-1:0];
        step_lo = {acc_lo[XLEN-2:0], 1'b1};
      end
    end else begin
      {step_hi, step_lo} = {mul_sum, acc_lo[XLEN-1:1]};
    end
  end

  // Sign correction on the values produced by the final iteration
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo, rem, fin;

  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_res ? -prod : prod;
    quo      = neg_res ? -step_lo : step_lo;
    rem      = neg_rem ? -step_hi : step_hi;
    case (op_q)
      OP_MUL:                       fin = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin = quo;
      default:                      fin = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      op_q    <= OP_MUL;
      cnt     <= '0;
      rd_q    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
      done    <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op_t'(op);
            rd_q    <= rd_in;
            acc_hi  <= '0;
            acc_lo  <= a_mag;
            mcand   <= b_mag;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (special) begin
              result <= special_res;
              rd_out <= rd_in;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              cnt   <= CNT_W'(XLEN - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            result <= fin;
            rd_out <= rd_q;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign stall = ((state == IDLE) & start & ~flush) | (state == CALC);

endmodule

// File: tb/tb_muldiv_ex.sv
// Scoreboard bench for muldiv_ex: expectations are queued at issue and retired on done.
module tb_muldiv_ex;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk, rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a_i, b_i;
  logic [4:0]  rd_i;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        done, busy, stall;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  int unsigned cyc    = 0;
  int unsigned stall_total = 0;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned lat;
    int unsigned cyc0;
    int unsigned st0;
  } exp_t;
  exp_t sb[$];

  muldiv_ex #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .A(a_i), .B(b_i), .rd_in(rd_i), .result(result), .rd_out(rd_out),
    .done(done), .busy(busy), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb_, ua, ub, p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      MUL:    begin p = sa * sb_; return p[31:0];  end
      MULH:   begin p = sa * sb_; return p[63:32]; end
      MULHSU: begin p = sa * ub;  return p[63:32]; end
      MULHU:  begin p = ua * ub;  return p[63:32]; end
      DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $signed(a) / $signed(b);
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:    return (b == 0) ? a : ovf ? 32'h0 : $signed(a) % $signed(b);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return o[2] && ((b == 0) ||
           (!o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  // Retire expectations on done; flag spurious done pulses and overdue results
  always @(negedge clk) begin
    exp_t e;
    if (stall === 1'b1) stall_total++;
    if (sb.size() == 0) begin
      checks++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL spurious_done: got done=%b required 0 (cycle %0d)", done, cyc);
      end
    end else if (done === 1'b1) begin
      e = sb.pop_front();
      checks++;
      if (result !== e.res) begin
        fails++;
        $display("FAIL result: got %h required %h", result, e.res);
      end
      checks++;
      if (rd_out !== e.rd) begin
        fails++;
        $display("FAIL rd_out: got %0d required %0d", rd_out, e.rd);
      end
      checks++;
      if ((cyc - e.cyc0) != e.lat) begin
        fails++;
        $display("FAIL done_edge: got E%0d required E%0d", cyc - e.cyc0, e.lat);
      end
      checks++;
      if ((stall_total - e.st0) != e.lat) begin
        fails++;
        $display("FAIL stall_cycles: got %0d required %0d", stall_total - e.st0, e.lat);
      end
    end else if ((cyc - sb[0].cyc0) > 40) begin
      e = sb.pop_front();
      checks++;
      fails++;
      $display("FAIL timeout: no done after %0d cycles, required result %h", cyc - e.cyc0, e.res);
    end
  end

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(posedge clk); #1;
    start = 1'b1; op = o; a_i = a; b_i = b; rd_i = rd;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res);
    exp_t e;
    drive(o, a, b, rd);
    e.res  = exp_res;
    e.rd   = rd;
    e.lat  = is_special(o, a, b) ? 1 : 33;
    e.cyc0 = cyc;
    e.st0  = stall_total;
    sb.push_back(e);
    last_res = exp_res;
    last_rd  = rd;
  endtask

  // Keeps start asserted (instruction held in EX) while scrambling operands mid-operation
  task automatic finish_op();
    @(posedge clk);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      op = 3'($urandom); a_i = $urandom; b_i = $urandom; rd_i = 5'($urandom);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a_i = '0; b_i = '0; rd_i = '0;
    last_res = '0; last_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h required 0", result); end
    checks++; if (rd_out !== 5'd0)  begin fails++; $display("FAIL reset_rd_out: got %0d required 0", rd_out); end
    checks++; if (done !== 1'b0)    begin fails++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (stall !== 1'b0)   begin fails++; $display("FAIL reset_stall: got %b required 0", stall); end
    rst = 1'b1;
  endtask

  task automatic test_mul();
    issue(MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB); finish_op();
    issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE); finish_op();
    issue(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000); finish_op();
    issue(MULHSU, 32'hFFFF_FFFF, 32'd2,        5'd8,  32'hFFFF_FFFF); finish_op();
    issue(MULH,   32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000); finish_op();
    idle();
  endtask

  task automatic test_div();
    issue(DIV,  32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD); finish_op();
    issue(REM,  32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF); finish_op();
    issue(DIVU, 32'd100,       32'd7, 5'd12, 32'd14);        finish_op();
    issue(REMU, 32'd100,       32'd7, 5'd13, 32'd2);         finish_op();
    issue(DIV,  32'd7, 32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD); finish_op();
    idle();
  endtask

  task automatic test_special();
    issue(DIVU, 32'd5,         32'd0,         5'd20, 32'hFFFF_FFFF); finish_op();
    issue(REM,  32'd5,         32'd0,         5'd21, 32'd5);         finish_op();
    issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000); finish_op();
    issue(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h0);         finish_op();
    issue(DIV,  32'hFFFF_FFF0, 32'd0,         5'd24, 32'hFFFF_FFFF); finish_op();
    issue(REMU, 32'hDEAD_BEEF, 32'd0,         5'd25, 32'hDEAD_BEEF); finish_op();
    idle();
  endtask

  task automatic test_flush();
    logic [31:0] a, b;
    drive(DIV, 32'd1000, 32'd7, 5'd9);
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)      begin fails++; $display("FAIL flush_busy: got %b required 0", busy); end
    checks++; if (stall !== 1'b0)     begin fails++; $display("FAIL flush_stall: got %b required 0", stall); end
    checks++; if (result !== last_res) begin fails++; $display("FAIL flush_result: got %h required %h", result, last_res); end
    checks++; if (rd_out !== last_rd) begin fails++; $display("FAIL flush_rd_out: got %0d required %0d", rd_out, last_rd); end
    start = 1'b1; flush = 1'b1; op = MUL; a_i = 32'd3; b_i = 32'd4;
    #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_start_stall: got %b required 0", stall); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_start_accepted: got busy=%b required 0", busy); end
    start = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    a = $urandom; b = $urandom;
    issue(MUL, a, b, 5'd30, model(MUL, a, b)); finish_op();
    idle();
  endtask

  task automatic test_reset_mid();
    drive(MUL, 32'h1234_5678, 32'h0000_9ABC, 5'd3);
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1 start = 1'b0; rst = 1'b0;
    #1;
    checks++; if (result !== 32'h0) begin fails++; $display("FAIL rstmid_result: got %h required 0", result); end
    checks++; if (rd_out !== 5'd0)  begin fails++; $display("FAIL rstmid_rd_out: got %0d required 0", rd_out); end
    checks++; if (done !== 1'b0)    begin fails++; $display("FAIL rstmid_done: got %b required 0", done); end
    checks++; if (busy !== 1'b0)    begin fails++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    checks++; if (stall !== 1'b0)   begin fails++; $display("FAIL rstmid_stall: got %b required 0", stall); end
    @(negedge clk);
    rst = 1'b1;
    last_res = '0; last_rd = '0;
    issue(DIVU, 32'd9, 32'd3, 5'd17, 32'd3); finish_op();
    idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'h0 : (i[0] ? $urandom : 32'($urandom_range(1, 300)));
      issue(o, a, b, 5'(i + 1), model(o, a, b));
      finish_op();
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0)       begin fails++; $display("FAIL done_width: got %b required 0", done); end
    checks++; if (busy !== 1'b0)       begin fails++; $display("FAIL post_done_busy: got %b required 0", busy); end
    checks++; if (result !== last_res) begin fails++; $display("FAIL result_hold: got %h required %h", result, last_res); end
    checks++; if (rd_out !== last_rd)  begin fails++; $display("FAIL rd_hold: got %0d required %0d", rd_out, last_rd); end
    start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL outstanding: got %0d pending results required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d required < 20000", cyc);
    $fatal(1);
  end

endmodule
